// File: rtl/apb_sram_pkg.sv
// apb_sram_pkg: shared widths, types and requester definitions for the APB SRAM subsystem.
`default_nettype none

package apb_sram_pkg;

   localparam int ADDR_WIDTH = 8;
   localparam int DATA_WIDTH = 32;
   localparam int APB_REQ_TIMEOUT_DEFAULT = 16;

   typedef logic [ADDR_WIDTH-1:0]   apb_addr_t;
   typedef logic [DATA_WIDTH-1:0]   apb_data_t;
   typedef logic [DATA_WIDTH/8-1:0] apb_strb_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2,
      RESP   = 2'd3
   } apb_req_state_e;

   typedef struct packed {
      logic      write;
      apb_addr_t addr;
      apb_data_t wdata;
      apb_strb_t strb;
   } apb_req_cmd_t;

   typedef struct packed {
      apb_data_t rdata;
      logic      err;
      logic      timeout;
   } apb_req_rsp_t;

endpackage

`default_nettype wire

// File: rtl/apb_sram_requester.sv
// apb_sram_requester: single-outstanding APB initiator with command/response handshakes
// and an ACCESS-phase timeout. Revision 1.0.
`default_nettype none

module apb_sram_requester
   import apb_sram_pkg::*;
#(
   parameter int ADDR_WIDTH     = apb_sram_pkg::ADDR_WIDTH,
   parameter int DATA_WIDTH     = apb_sram_pkg::DATA_WIDTH,
   parameter int TIMEOUT_CYCLES = APB_REQ_TIMEOUT_DEFAULT
) (
   input  logic                    pclk,
   input  logic                    presetn,
   // command channel
   input  logic                    cmd_valid,
   output logic                    cmd_ready,
   input  logic                    cmd_write,
   input  logic [ADDR_WIDTH-1:0]   cmd_addr,
   input  logic [DATA_WIDTH-1:0]   cmd_wdata,
   input  logic [DATA_WIDTH/8-1:0] cmd_strb,
   // response channel
   output logic                    rsp_valid,
   input  logic                    rsp_ready,
   output logic [DATA_WIDTH-1:0]   rsp_rdata,
   output logic                    rsp_err,
   output logic                    rsp_timeout,
   // APB
   output logic                    psel,
   output logic                    penable,
   output logic                    pwrite,
   output logic [ADDR_WIDTH-1:0]   paddr,
   output logic [DATA_WIDTH-1:0]   pwdata,
   output logic [DATA_WIDTH/8-1:0] pstrb,
   input  logic [DATA_WIDTH-1:0]   prdata,
   input  logic                    pready,
   input  logic                    pslverr
);

   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   // Value held during the last permitted wait cycle; reaching it without pready aborts.
   localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   apb_req_state_e   state_q;
   apb_req_state_e   state_d;
   apb_req_cmd_t     cmd_q;
   apb_req_rsp_t     rsp_q;
   logic [CNT_W-1:0] tmo_cnt;
   logic             misaligned;
   logic             tmo_hit;

   assign misaligned = (cmd_addr[1:0] != 2'b00);
   assign tmo_hit    = (tmo_cnt == TMO_LAST);

   always_ff @(posedge pclk) begin
      if (!presetn) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cmd_ready = 1'b0;
      psel      = 1'b0;
      penable   = 1'b0;
      rsp_valid = 1'b0;
      case (state_q)
         IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid) begin
               state_d = misaligned ? RESP : SETUP;
            end
         end
         SETUP: begin
            psel    = 1'b1;
            state_d = ACCESS;
         end
         ACCESS: begin
            psel    = 1'b1;
            penable = 1'b1;
            if (pready || tmo_hit) begin
               state_d = RESP;
            end
         end
         RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge pclk) begin
      if (!presetn) begin
         cmd_q   <= '0;
         rsp_q   <= '0;
         tmo_cnt <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (cmd_valid) begin
                  cmd_q <= '{write: cmd_write, addr: cmd_addr, wdata: cmd_wdata, strb: cmd_strb};
                  rsp_q <= '{rdata: '0, err: misaligned, timeout: 1'b0};
               end
            end
            ACCESS: begin
               if (pready) begin
                  // pready wins even on the final wait cycle
                  rsp_q <= '{rdata:   (cmd_q.write || pslverr) ? '0 : prdata,
                             err:     pslverr,
                             timeout: 1'b0};
               end else begin
                  tmo_cnt <= tmo_cnt + 1'b1;
                  if (tmo_hit) begin
                     rsp_q <= '{rdata: '0, err: 1'b1, timeout: 1'b1};
                  end
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  tmo_cnt <= '0;
               end
            end
            default: ;
         endcase
      end
   end

   assign pwrite      = cmd_q.write;
   assign paddr       = cmd_q.addr;
   assign pwdata      = cmd_q.wdata;
   assign pstrb       = cmd_q.write ? cmd_q.strb : '0;
   assign rsp_rdata   = rsp_q.rdata;
   assign rsp_err     = rsp_q.err;
   assign rsp_timeout = rsp_q.timeout;

endmodule

`default_nettype wire

// File: tb/tb_apb_sram_requester.sv
// tb_apb_sram_requester: directed self-checking bench for apb_sram_requester.
`default_nettype none

module tb_apb_sram_requester;

   logic        pclk;
   logic        presetn;
   logic        cmd_valid;
   logic        cmd_ready;
   logic        cmd_write;
   logic [7:0]  cmd_addr;
   logic [31:0] cmd_wdata;
   logic [3:0]  cmd_strb;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic        rsp_timeout;
   logic        psel;
   logic        penable;
   logic        pwrite;
   logic [7:0]  paddr;
   logic [31:0] pwdata;
   logic [3:0]  pstrb;
   logic [31:0] prdata;
   logic        pready;
   logic        pslverr;

   int n_pass  = 0;
   int n_total = 0;

   apb_sram_requester #(
      .ADDR_WIDTH     (8),
      .DATA_WIDTH     (32),
      .TIMEOUT_CYCLES (16)
   ) dut (
      .pclk        (pclk),
      .presetn     (presetn),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_write   (cmd_write),
      .cmd_addr    (cmd_addr),
      .cmd_wdata   (cmd_wdata),
      .cmd_strb    (cmd_strb),
      .rsp_valid   (rsp_valid),
      .rsp_ready   (rsp_ready),
      .rsp_rdata   (rsp_rdata),
      .rsp_err     (rsp_err),
      .rsp_timeout (rsp_timeout),
      .psel        (psel),
      .penable     (penable),
      .pwrite      (pwrite),
      .paddr       (paddr),
      .pwdata      (pwdata),
      .pstrb       (pstrb),
      .prdata      (prdata),
      .pready      (pready),
      .pslverr     (pslverr)
   );

   initial pclk = 1'b0;
   always #5 pclk = ~pclk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
   endtask

   task automatic tick();
      @(negedge pclk);
   endtask

   // Presents one command for a single edge; returns in the cycle after the handshake.
   task automatic issue(input logic w, input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
      check("cmd_ready_idle", cmd_ready, 1);
      cmd_valid = 1'b1;
      cmd_write = w;
      cmd_addr  = a;
      cmd_wdata = d;
      cmd_strb  = s;
      tick();
      cmd_valid = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      presetn   = 1'b0;
      cmd_valid = 1'b0;
      cmd_write = 1'b0;
      cmd_addr  = '0;
      cmd_wdata = '0;
      cmd_strb  = '0;
      rsp_ready = 1'b1;
      prdata    = '0;
      pready    = 1'b0;
      pslverr   = 1'b0;
      tick();
      tick();

      // reset state
      check("rst_psel", psel, 0);
      check("rst_penable", penable, 0);
      check("rst_pwrite", pwrite, 0);
      check("rst_paddr", paddr, 0);
      check("rst_pwdata", pwdata, 0);
      check("rst_pstrb", pstrb, 0);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_rsp_fields", {rsp_rdata[29:0], rsp_err, rsp_timeout}, 0);
      check("rst_cmd_ready", cmd_ready, 1);
      presetn = 1'b1;
      tick();

      // write 0xDEADBEEF to 0x04, zero wait states
      pready = 1'b1;
      prdata = 32'h0BAD0BAD;
      issue(1'b1, 8'h04, 32'hDEADBEEF, 4'hF);
      check("wr_setup_ctl", {psel, penable}, 2'b10);
      check("wr_setup_paddr", paddr, 32'h04);
      check("wr_setup_pwdata", pwdata, 32'hDEADBEEF);
      check("wr_setup_pstrb", pstrb, 4'hF);
      check("wr_setup_pwrite", pwrite, 1);
      check("wr_setup_cmd_ready", cmd_ready, 0);
      tick();
      check("wr_access_ctl", {psel, penable}, 2'b11);
      check("wr_access_rsp_valid", rsp_valid, 0);
      tick();
      check("wr_rsp_valid", rsp_valid, 1);
      check("wr_rsp_err", rsp_err, 0);
      check("wr_rsp_rdata", rsp_rdata, 0);
      check("wr_rsp_psel", psel, 0);
      tick();
      check("wr_back_idle", {cmd_ready, rsp_valid}, 2'b10);

      // read 0x08 with two wait states
      pready = 1'b0;
      prdata = 32'h12345678;
      issue(1'b0, 8'h08, 32'hFFFFFFFF, 4'hF);
      check("rd_setup_pstrb", pstrb, 0);
      check("rd_setup_pwrite", pwrite, 0);
      for (int i = 0; i < 3; i++) begin
         tick();
         if (i == 2) pready = 1'b1;
         check("rd_wait_ctl", {psel, penable}, 2'b11);
         check("rd_wait_paddr", paddr, 32'h08);
         check("rd_wait_rsp_valid", rsp_valid, 0);
      end
      tick();
      check("rd_rsp_valid", rsp_valid, 1);
      check("rd_rsp_rdata", rsp_rdata, 32'h12345678);
      check("rd_rsp_err", rsp_err, 0);
      tick();

      // read 0x0C with slave error
      pready  = 1'b1;
      pslverr = 1'b1;
      prdata  = 32'hAAAA5555;
      issue(1'b0, 8'h0C, 32'h0, 4'h0);
      tick();
      tick();
      check("slverr_rsp_valid", rsp_valid, 1);
      check("slverr_rsp_err", rsp_err, 1);
      check("slverr_rsp_timeout", rsp_timeout, 0);
      check("slverr_rsp_rdata", rsp_rdata, 0);
      pslverr = 1'b0;
      tick();

      // misaligned command to 0x06
      issue(1'b1, 8'h06, 32'h11111111, 4'hF);
      check("misal_psel", psel, 0);
      check("misal_rsp_valid", rsp_valid, 1);
      check("misal_rsp_err", rsp_err, 1);
      check("misal_rsp_timeout", rsp_timeout, 0);
      tick();
      check("misal_back_idle", cmd_ready, 1);

      // timeout: pready never rises
      pready = 1'b0;
      prdata = 32'h77777777;
      issue(1'b0, 8'h10, 32'h0, 4'h0);
      for (int i = 1; i <= 16; i++) begin
         tick();
         check("tmo_access_ctl", {psel, penable}, 2'b11);
      end
      tick();
      check("tmo_psel", {psel, penable}, 2'b00);
      check("tmo_rsp_valid", rsp_valid, 1);
      check("tmo_rsp_err", rsp_err, 1);
      check("tmo_rsp_timeout", rsp_timeout, 1);
      check("tmo_rsp_rdata", rsp_rdata, 0);
      tick();

      // pready on the final allowed ACCESS cycle completes normally
      prdata = 32'h55AA55AA;
      issue(1'b0, 8'h14, 32'h0, 4'h0);
      for (int i = 1; i <= 16; i++) begin
         tick();
         if (i == 16) pready = 1'b1;
         check("edge_access_ctl", {psel, penable}, 2'b11);
      end
      tick();
      check("edge_rsp_valid", rsp_valid, 1);
      check("edge_rsp_err", rsp_err, 0);
      check("edge_rsp_timeout", rsp_timeout, 0);
      check("edge_rsp_rdata", rsp_rdata, 32'h55AA55AA);
      tick();

      // response back-pressure
      rsp_ready = 1'b0;
      pready    = 1'b1;
      prdata    = 32'hCAFEF00D;
      issue(1'b0, 8'h18, 32'h0, 4'h0);
      tick();
      tick();
      prdata = 32'h0;
      for (int i = 0; i < 5; i++) begin
         check("bp_rsp_valid", rsp_valid, 1);
         check("bp_rsp_rdata", rsp_rdata, 32'hCAFEF00D);
         check("bp_rsp_err", rsp_err, 0);
         check("bp_cmd_ready", cmd_ready, 0);
         tick();
      end
      rsp_ready = 1'b1;
      check("bp_hold_last", rsp_valid, 1);
      tick();
      check("bp_back_idle", {cmd_ready, rsp_valid}, 2'b10);

      // reset during ACCESS
      pready = 1'b0;
      issue(1'b1, 8'h1C, 32'h99999999, 4'h3);
      tick();
      check("rstmid_access", {psel, penable}, 2'b11);
      presetn = 1'b0;
      tick();
      check("rstmid_psel", {psel, penable}, 2'b00);
      check("rstmid_rsp_valid", rsp_valid, 0);
      check("rstmid_cmd_ready", cmd_ready, 1);
      check("rstmid_paddr", paddr, 0);
      presetn = 1'b1;
      tick();
      check("rstmid_no_rsp", rsp_valid, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/apb_sram_requester.md
Name: apb_sram_requester

Overview:
- APB requester (initiator) that drives transfers into the APB SRAM completer.
- Accepts one command at a time on a valid/ready request channel and sequences the APB SETUP and ACCESS phases.
- Returns read data and error status on a valid/ready response channel.
- Sits between the SoC-side controller and the SRAM APB slave port; also serves as the bench-side driver for SRAM verification.

Parameters:
- ADDR_WIDTH, apb_sram_pkg::ADDR_WIDTH (8): APB address width.
- DATA_WIDTH, apb_sram_pkg::DATA_WIDTH (32): APB data width.
- TIMEOUT_CYCLES, 16: maximum ACCESS-phase cycles with pready low before abort; legal range 1..255.

Ports:
- pclk  in  1  APB clock; sole clock.
- presetn  in  1  synchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_WIDTH  byte address.
- cmd_wdata  in  DATA_WIDTH  write data.
- cmd_strb  in  DATA_WIDTH/8  write byte strobes.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed.
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes and errors.
- rsp_err  out  1  pslverr, misalignment, or timeout.
- rsp_timeout  out  1  error cause was timeout.
- psel, penable, pwrite  out  1 each  APB control.
- paddr  out  ADDR_WIDTH  APB address.
- pwdata  out  DATA_WIDTH  APB write data.
- pstrb  out  DATA_WIDTH/8  APB strobes; forced to 0 on reads.
- prdata  in  DATA_WIDTH  APB read data.
- pready  in  1  completer ready.
- pslverr  in  1  completer error.

Behaviour:
- Reset: one clock and reset domain. While presetn is low at a pclk edge:
  - state goes to IDLE.
  - psel, penable, pwrite, paddr, pwdata, pstrb, rsp_valid, rsp_rdata, rsp_err and rsp_timeout all go to 0.
  - The timeout counter clears.
  - Reset mid-transfer drops psel immediately; no response is issued.
- cmd_ready = 1 only in IDLE, combinational from state. No command buffering; one outstanding transfer.
- FSM IDLE -> SETUP -> ACCESS -> RESP -> IDLE.
- IDLE:
  - On handshake, register addr, wdata, strb and write.
  - If cmd_addr[1:0] != 0, go to RESP with rsp_err=1 and no APB activity.
  - Otherwise go to SETUP.
- SETUP (exactly 1 cycle): psel=1, penable=0; paddr, pwrite, pwdata and pstrb are valid. Next state is ACCESS.
- ACCESS: psel=1, penable=1; all APB outputs stay stable.
  - pready=1: capture prdata (reads only, else 0) and pslverr into the response registers; go to RESP; psel and penable drop on the next cycle.
  - pready=0: increment the counter. When it reaches TIMEOUT_CYCLES, abort: drop psel and penable, set rsp_err=1 and rsp_timeout=1, go to RESP.
- RESP: rsp_valid=1, psel=0, and rsp fields hold stable until rsp_ready. On the rsp_ready handshake go to IDLE, clear rsp_valid, clear the counter.
- Minimum latency, cmd handshake to rsp_valid, with pready=1 in the first ACCESS cycle: 3 cycles. SETUP, ACCESS and RESP each take one cycle.
- Back-to-back: cmd_ready is high the cycle after the rsp handshake. Minimum 4 cycles per transfer with rsp_ready tied high.
- pslverr is sampled only when pready=1; prdata on error is forwarded as 0.
- pready arriving on the exact cycle the counter reaches TIMEOUT_CYCLES: pready wins, normal completion.
- Counter width is $clog2(TIMEOUT_CYCLES+1); no wrap, because it saturates at the abort.

Decomposition:
- apb_sram_pkg adds:
  - state enum apb_req_state_e {IDLE, SETUP, ACCESS, RESP}.
  - apb_strb_t, logic [DATA_WIDTH/8-1:0].
  - struct apb_req_cmd_t {write, addr, wdata, strb}.
  - struct apb_req_rsp_t {rdata, err, timeout}.
  - constant APB_REQ_TIMEOUT_DEFAULT = 16.
- Reuse apb_addr_t and apb_data_t. Single module; no sub-module needed (the timeout counter stays inline).

Test Plan:
- Write 0xDEADBEEF to 0x04 with strb 0xF, pready=1 -> SETUP with paddr=0x04, pwdata=0xDEADBEEF, pstrb=0xF; ACCESS the next cycle; rsp_valid 3 cycles after handshake with rsp_err=0 and rsp_rdata=0.
- Read 0x08, completer inserts 2 wait states, prdata=0x12345678 -> penable held 3 cycles, paddr stable; rsp_rdata=0x12345678, rsp_err=0.
- Read 0x0C with pslverr=1 on the pready cycle -> rsp_err=1, rsp_timeout=0, rsp_rdata=0.
- Command to 0x06 -> psel never asserts; rsp_valid 1 cycle after handshake with rsp_err=1.
- pready held low with TIMEOUT_CYCLES=16 -> 16 ACCESS cycles, then psel=0; rsp_err=1, rsp_timeout=1. Repeat with pready rising on cycle 16 -> normal completion.
- Other cases:
  - rsp_ready low 5 cycles -> rsp fields stable and cmd_ready=0 throughout.
  - presetn low during ACCESS -> next cycle psel=0, rsp_valid=0, cmd_ready=1.
